// File: rtl/fetch_pkg.sv
// Purpose: shared types and constants for the instruction fetch sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: fetch_state_t FSM encoding, EBREAK opcode, fetch_entry_t queue entry.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Purpose: circular fetch buffer, one write port, two head-relative read ports.
// Latency: a push at edge N is readable after edge N; reads come from registered state only.
// Backpressure: push dropped when full at cycle start; pop clamped to the current count.
// Ports: i_clk/i_rst_n (sync, active-low), i_flush clears pointers and count,
//        i_push/i_push_dat write at tail, i_pop (0..3, 3 treated as 2),
//        o_rd0_dat/o_rd1_dat = head/head+1, o_vld per read slot, o_count occupancy.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned QDEPTH = 4,
   parameter int unsigned PW     = $clog2(QDEPTH),
   parameter int unsigned CW     = $clog2(QDEPTH) + 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_flush,
   input  logic          i_push,
   input  fetch_entry_t  i_push_dat,
   input  logic [1:0]    i_pop,
   output fetch_entry_t  o_rd0_dat,
   output fetch_entry_t  o_rd1_dat,
   output logic [1:0]    o_vld,
   output logic [CW-1:0] o_count
);

   fetch_entry_t  r_mem [QDEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic [1:0]    w_take_req;
   logic [1:0]    w_take;
   logic          w_do_push;

   always_comb begin
      w_take_req = (i_pop == 2'd3) ? 2'd2 : i_pop;
      // Requested take above occupancy only happens when count is 0 or 1,
      // so the low two count bits are the exact clamped value.
      if (CW'(w_take_req) > r_count) w_take = r_count[1:0];
      else                           w_take = w_take_req;
      // Full is judged on the start-of-cycle count, so a same-cycle pop
      // does not make room for a push.
      w_do_push = i_push && !i_flush && (r_count != CW'(QDEPTH));
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + PW'(w_take);
         r_tail  <= r_tail + PW'(w_do_push);
         r_count <= r_count + CW'(w_do_push) - CW'(w_take);
      end
   end

   // Storage carries no reset; o_vld qualifies every read.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && w_do_push) r_mem[r_tail] <= i_push_dat;
   end

   assign o_rd0_dat = r_mem[r_head];
   assign o_rd1_dat = r_mem[r_head + PW'(1)];
   assign o_vld     = {(r_count >= CW'(2)), (r_count != '0)};
   assign o_count   = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Purpose: owns the PC and fetch FSM, reads one word per cycle into a queue, presents two to decode.
// Latency: fetched word visible one cycle after its push edge; redirect empties outputs the next cycle.
// Backpressure: fetch stalls (PC holds) while the queue is full; decode pops 0..2 per cycle.
// Ports: clk, rst_n (sync, active-low), start, imem_addr/imem_rdata (combinational memory),
//        redirect_valid/redirect_pc, deq_take, out_valid, out_instr0/1, out_pc0/1, halted.
// Build option: FETCH_HALT_EN -- fetching EBREAK enqueues it and halts until a redirect.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned QDEPTH   = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic [1:0]  deq_take,
   output logic [1:0]  out_valid,
   output logic [31:0] out_instr0,
   output logic [31:0] out_instr1,
   output logic [31:0] out_pc0,
   output logic [31:0] out_pc1,
   output logic        halted
);

   localparam int unsigned CW = $clog2(QDEPTH) + 1;

   fetch_state_t  r_state;
   fetch_state_t  w_state_nxt;
   logic [31:0]   r_pc;
   logic [31:0]   w_pc_nxt;
   logic          w_push;
   logic          w_full;
   logic [CW-1:0] w_count;
   logic [1:0]    w_vld;
   fetch_entry_t  w_rd0;
   fetch_entry_t  w_rd1;
   fetch_entry_t  w_push_dat;

   assign w_full     = (w_count == CW'(QDEPTH));
   assign w_push_dat = '{pc: r_pc, instr: imem_rdata};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      case (r_state)
         IDLE: begin
            // A redirect in IDLE only loads the PC; it outranks start.
            if (!redirect_valid && start) w_state_nxt = RUN;
         end
         RUN: begin
            w_push = !redirect_valid && !w_full;
`ifdef FETCH_HALT_EN
            if (w_push && (imem_rdata == EBREAK)) w_state_nxt = HALT;
`endif
         end
         HALT: begin
            if (redirect_valid) w_state_nxt = RUN;
         end
         default: w_state_nxt = IDLE;
      endcase

      if (redirect_valid) w_pc_nxt = redirect_pc & 32'hFFFF_FFFC;
      else if (w_push)    w_pc_nxt = r_pc + 32'd4;
      else                w_pc_nxt = r_pc;
   end

   fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_flush    (redirect_valid),
      .i_push     (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (deq_take),
      .o_rd0_dat  (w_rd0),
      .o_rd1_dat  (w_rd1),
      .o_vld      (w_vld),
      .o_count    (w_count)
   );

   assign imem_addr  = r_pc;
   assign out_valid  = w_vld;
   assign out_instr0 = w_vld[0] ? w_rd0.instr : 32'd0;
   assign out_pc0    = w_vld[0] ? w_rd0.pc    : 32'd0;
   assign out_instr1 = w_vld[1] ? w_rd1.instr : 32'd0;
   assign out_pc1    = w_vld[1] ? w_rd1.pc    : 32'd0;

`ifdef FETCH_HALT_EN
   assign halted = (r_state == HALT);
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [1:0]  deq_take;
   logic [1:0]  out_valid;
   logic [31:0] out_instr0;
   logic [31:0] out_instr1;
   logic [31:0] out_pc0;
   logic [31:0] out_pc1;
   logic        halted;

   logic [31:0] mem [16];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign imem_rdata = mem[imem_addr[5:2]];

   fetch_sequencer #(.QDEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .deq_take       (deq_take),
      .out_valid      (out_valid),
      .out_instr0     (out_instr0),
      .out_instr1     (out_instr1),
      .out_pc0        (out_pc0),
      .out_pc1        (out_pc1),
      .halted         (halted)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      mem[0] = 32'hFFC4_A303;
      mem[1] = 32'h0064_A423;
      mem[2] = 32'h0062_E233;
      mem[3] = 32'hFE42_0AE3;
      for (int i = 4; i < 16; i++) mem[i] = 32'h0B00_0000 + i;

      rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; deq_take = 2'd0;
      step(); step();
      chk("rst_addr",   imem_addr, 32'h0);
      chk("rst_valid",  {30'd0, out_valid}, 32'd0);
      chk("rst_instr0", out_instr0, 32'h0);
      chk("rst_pc1",    out_pc1, 32'h0);
      chk("rst_halted", {31'd0, halted}, 32'd0);

      rst_n = 1'b1;
      step();
      chk("idle_hold_addr", imem_addr, 32'h0);

      // Fill: edge 1 enters RUN, edges 2..5 push 0x0..0xC, edge 6 stalls full.
      start = 1'b1;
      step();
      chk("enter_run_valid", {30'd0, out_valid}, 32'd0);
      step();
      chk("first_push_valid", {30'd0, out_valid}, 32'd1);
      chk("first_push_instr0", out_instr0, 32'hFFC4_A303);
      chk("first_push_instr1_zero", out_instr1, 32'h0);
      step(); step(); step(); step();
      chk("full_valid",  {30'd0, out_valid}, 32'd3);
      chk("full_instr0", out_instr0, 32'hFFC4_A303);
      chk("full_pc0",    out_pc0, 32'h0);
      chk("full_instr1", out_instr1, 32'h0064_A423);
      chk("full_pc1",    out_pc1, 32'h4);
      chk("full_addr",   imem_addr, 32'h10);

      // Drain 2/cycle: first cycle full so no push (4->2), second pushes 0x10 (2->1).
      deq_take = 2'd2;
      step();
      chk("drain1_valid",  {30'd0, out_valid}, 32'd3);
      chk("drain1_instr0", out_instr0, 32'h0062_E233);
      chk("drain1_instr1", out_instr1, 32'hFE42_0AE3);
      chk("drain1_pc1",    out_pc1, 32'hC);
      chk("drain1_addr",   imem_addr, 32'h10);
      step();
      chk("drain2_valid",  {30'd0, out_valid}, 32'd1);
      chk("drain2_pc0",    out_pc0, 32'h10);
      chk("drain2_instr0", out_instr0, 32'h0B00_0004);
      chk("drain2_addr",   imem_addr, 32'h14);

      // Steady state: one in, one out each cycle.
      deq_take = 2'd1;
      step();
      chk("steady1_pc0", out_pc0, 32'h14);
      step();
      chk("steady2_pc0", out_pc0, 32'h18);
      step();
      chk("steady3_pc0",   out_pc0, 32'h1C);
      chk("steady3_valid", {30'd0, out_valid}, 32'd1);

      // deq_take=3 with a single entry pops exactly one.
      deq_take = 2'd3;
      step();
      chk("take3_cnt1_valid", {30'd0, out_valid}, 32'd1);
      chk("take3_cnt1_pc0",   out_pc0, 32'h20);
      chk("take3_cnt1_addr",  imem_addr, 32'h24);

      deq_take = 2'd0;
      step();
      chk("hold_valid",  {30'd0, out_valid}, 32'd3);
      chk("hold_pc1",    out_pc1, 32'h24);
      chk("hold_instr1", out_instr1, 32'h0B00_0009);

      deq_take = 2'd3;
      step();
      chk("take3_cnt2_valid", {30'd0, out_valid}, 32'd1);
      chk("take3_cnt2_pc0",   out_pc0, 32'h28);

      // Redirect with misaligned target and a pending take.
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0007; deq_take = 2'd2;
      step();
      chk("redir_valid", {30'd0, out_valid}, 32'd0);
      chk("redir_pc0",   out_pc0, 32'h0);
      chk("redir_addr",  imem_addr, 32'h4);
      redirect_valid = 1'b0; deq_take = 2'd0;
      step();
      chk("redir_next_valid",  {30'd0, out_valid}, 32'd1);
      chk("redir_next_pc0",    out_pc0, 32'h4);
      chk("redir_next_instr0", out_instr0, 32'h0064_A423);

      // Reset mid-operation.
      rst_n = 1'b0; start = 1'b0;
      step();
      chk("midrst_addr",  imem_addr, 32'h0);
      chk("midrst_valid", {30'd0, out_valid}, 32'd0);

      // Redirect while IDLE loads the PC but does not start fetching.
      rst_n = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0010;
      step();
      chk("idle_redir_addr", imem_addr, 32'h10);
      redirect_valid = 1'b0;
      step();
      chk("idle_redir_stay_addr",  imem_addr, 32'h10);
      chk("idle_redir_stay_valid", {30'd0, out_valid}, 32'd0);

      // EBREAK at 0x8; redirect outranks start in IDLE.
      mem[2] = 32'h0010_0073;
      redirect_valid = 1'b1; redirect_pc = 32'h0; start = 1'b1;
      step();
      chk("ebrk_idle_addr", imem_addr, 32'h0);
      chk("ebrk_idle_valid", {30'd0, out_valid}, 32'd0);
      redirect_valid = 1'b0;
      step(); step(); step(); step();
      chk("ebrk_valid",  {30'd0, out_valid}, 32'd3);
      chk("ebrk_pc0",    out_pc0, 32'h0);
      chk("ebrk_addr",   imem_addr, 32'hC);
`ifdef FETCH_HALT_EN
      chk("ebrk_halted", {31'd0, halted}, 32'd1);
      step();
      chk("halt_hold_addr", imem_addr, 32'hC);
      chk("halt_hold_halted", {31'd0, halted}, 32'd1);
`else
      chk("ebrk_not_halted", {31'd0, halted}, 32'd0);
      step();
      chk("nohalt_addr", imem_addr, 32'h10);
      chk("nohalt_halted", {31'd0, halted}, 32'd0);
`endif
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      step();
      chk("unhalt_halted", {31'd0, halted}, 32'd0);
      chk("unhalt_addr",   imem_addr, 32'h0);
      chk("unhalt_valid",  {30'd0, out_valid}, 32'd0);
      redirect_valid = 1'b0;
      step();
      chk("unhalt_fetch_valid", {30'd0, out_valid}, 32'd1);
      chk("unhalt_fetch_pc0",   out_pc0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
